// File: rtl/mul_iter_unit_if.sv
// Start/done handshake and result bus of the iterative multiplier.
// master drives the request side, slave is the multiplier.
interface mul_iter_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result_lo;
  logic [WIDTH-1:0] result_hi;
  logic             flag_n;
  logic             flag_z;

  modport master (
    output start, op, a, b,
    input  busy, done, result_lo, result_hi, flag_n, flag_z
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result_lo, result_hi, flag_n, flag_z
  );
endinterface

// File: rtl/mul_iter_unit.sv
// Iterative shift-add multiplier (MUL/UMULL/SMULL), done pulse WIDTH+2 cycles after start.
// Optional MUL_ITER_EARLY_TERM_EN: leave RUN as soon as the remaining multiplier bits are zero.
module mul_iter_unit #(
  parameter int WIDTH = 32
) (
  input  logic            clk,
  input  logic            reset,
  mul_iter_unit_if.slave  bus
);
  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [1:0] OP_UMULL = 2'b01;
  localparam logic [1:0] OP_SMULL = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_SIGN,
    S_DONE
  } state_t;

  state_t               state_q;
  logic [1:0]           op_q;
  logic                 neg_q;
  logic [2*WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]     mplr_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 busy_q;
  logic                 done_q;
  logic [WIDTH-1:0]     lo_q;
  logic [WIDTH-1:0]     hi_q;
  logic                 n_q;
  logic                 z_q;

  logic                 smull_d;
  logic [WIDTH-1:0]     a_mag_d;
  logic [WIDTH-1:0]     b_mag_d;
  logic                 neg_d;
  logic [2*WIDTH-1:0]   acc_d;
  logic [WIDTH-1:0]     mplr_d;
  logic [2*WIDTH-1:0]   fin_d;
  logic                 long_d;
  logic [WIDTH-1:0]     lo_d;
  logic [WIDTH-1:0]     hi_d;
  logic                 n_d;
  logic                 z_d;
  logic                 last_d;

  always_comb begin
    smull_d = (bus.op == OP_SMULL);
    // Magnitudes are unsigned, so the most negative value maps cleanly to 2^(WIDTH-1).
    a_mag_d = (smull_d && bus.a[WIDTH-1]) ? (~bus.a + WIDTH'(1)) : bus.a;
    b_mag_d = (smull_d && bus.b[WIDTH-1]) ? (~bus.b + WIDTH'(1)) : bus.b;
    neg_d   = smull_d && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);

    acc_d   = mplr_q[0] ? (acc_q + mcand_q) : acc_q;
    mplr_d  = mplr_q >> 1;
    fin_d   = neg_q ? (~acc_q + (2*WIDTH)'(1)) : acc_q;

    long_d  = (op_q == OP_UMULL) || (op_q == OP_SMULL);
    lo_d    = fin_d[WIDTH-1:0];
    hi_d    = long_d ? fin_d[2*WIDTH-1:WIDTH] : '0;
    n_d     = long_d ? hi_d[WIDTH-1] : lo_d[WIDTH-1];
    z_d     = long_d ? (fin_d == '0) : (lo_d == '0);
  end

`ifdef MUL_ITER_EARLY_TERM_EN
  assign last_d = (cnt_q == LAST_CNT) || (mplr_d == '0);
`else
  assign last_d = (cnt_q == LAST_CNT);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      neg_q   <= 1'b0;
      mcand_q <= '0;
      mplr_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      lo_q    <= '0;
      hi_q    <= '0;
      n_q     <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            op_q    <= bus.op;
            neg_q   <= neg_d;
            mcand_q <= {{WIDTH{1'b0}}, a_mag_d};
            mplr_q  <= b_mag_d;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_RUN: begin
          acc_q   <= acc_d;
          mcand_q <= mcand_q << 1;
          mplr_q  <= mplr_d;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (last_d) begin
            state_q <= S_SIGN;
          end
        end
        S_SIGN: begin
          // Results and flags are registered here so they are valid in the DONE cycle.
          acc_q   <= fin_d;
          lo_q    <= lo_d;
          hi_q    <= hi_d;
          n_q     <= n_d;
          z_q     <= z_d;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= S_DONE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.result_lo = lo_q;
  assign bus.result_hi = hi_q;
  assign bus.flag_n    = n_q;
  assign bus.flag_z    = z_q;
endmodule

// File: tb/tb_mul_iter_unit.sv
// Randomized bench for mul_iter_unit with a 64-bit arithmetic reference model.
module tb_mul_iter_unit;
  logic clk = 1'b0;
  logic reset;

  mul_iter_unit_if #(.WIDTH(32)) bus ();
  mul_iter_unit #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [31:0] prev_lo, prev_hi;
  logic        prev_n, prev_z;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic ref_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] lo, output logic [31:0] hi,
                           output logic n, output logic z, output int lat);
    logic [63:0] p;
    logic [31:0] bm;
    logic        is_long;
    int          msb;
    is_long = (op == 2'b01) || (op == 2'b10);
    case (op)
      2'b01:   p = {32'b0, a} * {32'b0, b};
      2'b10:   p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
      default: p = {32'b0, a * b};
    endcase
    lo = p[31:0];
    hi = is_long ? p[63:32] : 32'd0;
    n  = is_long ? hi[31] : lo[31];
    z  = is_long ? (p == 64'd0) : (lo == 32'd0);
    bm = (op == 2'b10 && b[31]) ? (32'd0 - b) : b;
    msb = -1;
    for (int i = 0; i < 32; i++) if (bm[i]) msb = i;
`ifdef MUL_ITER_EARLY_TERM_EN
    lat = (msb < 0) ? 3 : 3 + msb;
`else
    lat = 34;
`endif
  endtask

  // Issues an op in the current cycle (DUT idle or in DONE) and returns in its DONE cycle.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int stray);
    logic [31:0] e_lo, e_hi;
    logic        e_n, e_z;
    int          lat, cyc;
    bit          seen, hold_bad;
    ref_model(op, a, b, e_lo, e_hi, e_n, e_z, lat);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    cyc = 0; seen = 0; hold_bad = 0;
    while (!seen && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      bus.start = (cyc == stray);
      bus.a = $urandom; bus.b = $urandom; bus.op = 2'($urandom_range(0, 3));
      if (bus.done === 1'b1) seen = 1;
      else if (bus.busy !== 1'b1 || bus.result_lo !== prev_lo || bus.result_hi !== prev_hi ||
               bus.flag_n !== prev_n || bus.flag_z !== prev_z) hold_bad = 1;
    end
    bus.start = 1'b0;
    check({tag, ".lat"}, 64'(cyc), 64'(lat));
    check({tag, ".lo"}, 64'(bus.result_lo), 64'(e_lo));
    check({tag, ".hi"}, 64'(bus.result_hi), 64'(e_hi));
    check({tag, ".nz"}, 64'({bus.flag_n, bus.flag_z}), 64'({e_n, e_z}));
    check({tag, ".busy_at_done"}, 64'(bus.busy), 64'd0);
    check({tag, ".hold"}, 64'(hold_bad), 64'd0);
    prev_lo = e_lo; prev_hi = e_hi; prev_n = e_n; prev_z = e_z;
  endtask

  task automatic idle_cycle(input string tag);
    @(posedge clk); #1;
    check({tag, ".idle_ctl"}, 64'({bus.busy, bus.done}), 64'd0);
    check({tag, ".idle_res"}, {bus.result_hi, bus.result_lo}, {prev_hi, prev_lo});
    check({tag, ".idle_nz"}, 64'({bus.flag_n, bus.flag_z}), 64'({prev_n, prev_z}));
  endtask

  initial begin
    logic [31:0] ra, rb;
    reset = 1'b1;
    bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst.ctl", 64'({bus.busy, bus.done}), 64'd0);
    check("rst.res", {bus.result_hi, bus.result_lo}, 64'd0);
    check("rst.nz", 64'({bus.flag_n, bus.flag_z}), 64'd0);
    prev_lo = '0; prev_hi = '0; prev_n = 1'b0; prev_z = 1'b0;

    run_op("mul7x6", 2'b00, 32'd7, 32'd6, -1);
    idle_cycle("after_mul");
    idle_cycle("after_mul2");
    run_op("umull_ff", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
    run_op("smull_m2x3", 2'b10, 32'hFFFF_FFFE, 32'd3, -1);
    run_op("smull_min", 2'b10, 32'h8000_0000, 32'h8000_0000, -1);
    idle_cycle("after_smull");
    run_op("mul_zero_stray", 2'b00, 32'h0001_0000, 32'h0001_0000, 10);
    idle_cycle("after_stray");
    run_op("mul3x5", 2'b00, 32'd3, 32'd5, -1);
    run_op("mul_b0", 2'b00, 32'd3, 32'd0, -1);
    run_op("op_rsvd", 2'b11, 32'h1234_5678, 32'h9ABC_DEF0, -1);
    idle_cycle("after_rsvd");

    // Reset in cycle 15 of a full-length op, then restart in cycle 16.
    bus.start = 1'b1; bus.op = 2'b01; bus.a = 32'hFFFF_FFFF; bus.b = 32'hFFFF_FFFF;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    check("midrun.busy", 64'(bus.busy), 64'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midrun.rst_ctl", 64'({bus.busy, bus.done}), 64'd0);
    check("midrun.rst_res", {bus.result_hi, bus.result_lo}, 64'd0);
    check("midrun.rst_nz", 64'({bus.flag_n, bus.flag_z}), 64'd0);
    prev_lo = '0; prev_hi = '0; prev_n = 1'b0; prev_z = 1'b0;
    run_op("after_rst", 2'b10, 32'hFFFF_FFF9, 32'd1000, -1);

    for (int k = 0; k < 40; k++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = $urandom;
        1: rb = $urandom >> $urandom_range(0, 31);
        2: rb = (32'd1 << $urandom_range(0, 31));
        default: rb = ($urandom_range(0, 1) == 1) ? 32'h8000_0000 : 32'hFFFF_FFFF;
      endcase
      if ($urandom_range(0, 7) == 0) rb = 32'd0;
      run_op("rand", 2'($urandom_range(0, 3)), ra, rb, -1);
      if ($urandom_range(0, 1) == 1) idle_cycle("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
